// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
//   state_t : FSM encoding (IDLE, RUN, DONE)
//   cnt_w() : width of the bit-position counter for a given operand width
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter only needs to reach WIDTH-1; WIDTH >= 2 keeps the result >= 1.
  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Combinational one-bit full subtractor: diff = a - b - b_in.
// Ports:
//   a, b, b_in : minuend bit, subtrahend bit, borrow-in
//   diff       : difference bit
//   b_out      : borrow-out
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic b_in,
  output logic diff,
  output logic b_out
);

  assign diff  = a ^ b ^ b_in;
  assign b_out = (~a & b) | (~(a ^ b) & b_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b - b_in, one bit per clock,
// behind a start/done handshake. One full-subtractor cell plus shift
// registers and a borrow flip-flop.
// Ports:
//   clk, rst      : clock (rising edge), async active-high reset
//   start         : request, sampled only in IDLE
//   a, b, b_in    : operands, captured on the accepting edge
//   busy          : high in RUN and DONE
//   done          : one-cycle pulse, result valid
//   diff, b_out   : result and final borrow, held until the next result
//   ovf           : signed overflow (only with SERIAL_SUBTRACTOR_OVERFLOW_EN)
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = cnt_w(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, diff_sh, diff_sh_nxt;
  logic [CW-1:0]    count;
  logic             borrow, borrow_nxt, d_bit, last;

  full_subtractor u_fs (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .b_in (borrow),
    .diff (d_bit),
    .b_out(borrow_nxt)
  );

  // New bit enters at the MSB; after WIDTH shifts the LSB result sits at bit 0.
  assign diff_sh_nxt = (diff_sh >> 1) | {d_bit, {(WIDTH-1){1'b0}}};
  assign last        = (count == CW'(WIDTH-1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      done  <= (state_nxt == DONE);
    end
  end

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  logic a_msb, b_msb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
    end else if (state == IDLE && start) begin
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
    end else if (state == RUN && last) begin
      // The final serial bit is the result MSB.
      ovf <= (a_msb != b_msb) && (d_bit != a_msb);
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      diff_sh <= '0;
      borrow  <= 1'b0;
      count   <= '0;
      diff    <= '0;
      b_out   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_sh   <= a;
          b_sh   <= b;
          borrow <= b_in;
          count  <= '0;
        end
        RUN: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          borrow  <= borrow_nxt;
          diff_sh <= diff_sh_nxt;
          count   <= count + 1'b1;
          if (last) begin
            diff  <= diff_sh_nxt;
            b_out <= borrow_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst, start, b_in;
  logic [WIDTH-1:0] a, b;
  logic             busy, done, b_out;
  logic [WIDTH-1:0] diff;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  logic             ovf;
`endif

  int tests = 0;
  int fails = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .b_in (b_in),
    .busy (busy),
    .done (done),
    .diff (diff),
    .b_out(b_out)
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    ,
    .ovf  (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a, b;
    logic             bin;
    logic [WIDTH-1:0] d;
    logic             bo;
    logic             ov;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Bounded wait for done, sampling on falling edges.
  task automatic wait_done(input string nm);
    for (int k = 0; k < 4*WIDTH && done !== 1'b1; k++) @(negedge clk);
    chk({nm, " done_seen"}, {31'd0, done}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int  busy_n, lat;
    bit  seen;
    @(negedge clk);
    a = v.a; b = v.b; b_in = v.bin; start = 1'b1;
    @(negedge clk);  // accept edge is behind us
    start = 1'b0;
    a = ~v.a; b = ~v.b; b_in = ~v.bin;  // must not affect the result
    busy_n = 0; lat = 0; seen = 0;
    for (int k = 1; k <= 4*WIDTH && !seen; k++) begin
      if (busy === 1'b1) busy_n++;
      if (done === 1'b1) begin seen = 1; lat = k - 1; end
      else @(negedge clk);
    end
    chk({nm, " done_seen"}, {31'd0, seen}, 32'd1);
    chk({nm, " latency"}, lat, WIDTH);
    chk({nm, " busy_cycles"}, busy_n, WIDTH + 1);
    chk({nm, " diff"}, diff, v.d);
    chk({nm, " b_out"}, b_out, v.bo);
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    chk({nm, " ovf"}, ovf, v.ov);
`endif
    @(negedge clk);
    chk({nm, " done_low"}, done, 1'b0);
    chk({nm, " busy_low"}, busy, 1'b0);
    chk({nm, " diff_hold"}, diff, v.d);
  endtask

  initial begin
    //                 a      b      bin  diff   bo   ovf
    vecs[0] = '{8'd10,  8'd3,  1'b0, 8'd7,  1'b0, 1'b0};
    vecs[1] = '{8'd3,   8'd10, 1'b0, 8'hF9, 1'b1, 1'b0};
    vecs[2] = '{8'h00,  8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'hFF,  8'h01, 1'b1, 8'hFD, 1'b0, 1'b0};
    vecs[4] = '{8'h80,  8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[5] = '{8'h7F,  8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[6] = '{8'd5,   8'd3,  1'b0, 8'd2,  1'b0, 1'b0};
    vecs[7] = '{8'h40,  8'hC0, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[8] = '{8'hAA,  8'h55, 1'b1, 8'h54, 1'b0, 1'b1};
    vecs[9] = '{8'd100, 8'd1,  1'b0, 8'd99, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; b_in = 1'b0;
    #1;
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset diff", diff, 8'd0);
    chk("reset b_out", b_out, 1'b0);
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    chk("reset ovf", ovf, 1'b0);
`endif
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // start pulses during RUN and DONE are ignored
    @(negedge clk);
    a = 8'd20; b = 8'd5; b_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 8'd1; b = 8'd2;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ign run busy", busy, 1'b1);
    wait_done("ign");
    chk("ign diff", diff, 8'd15);
    start = 1'b1;  // sampled on the DONE->IDLE edge
    @(negedge clk);
    start = 1'b0;
    chk("ign done busy", busy, 1'b0);
    chk("ign done diff", diff, 8'd15);
    @(negedge clk);
    chk("ign idle busy", busy, 1'b0);

    // start held high: re-accepted on the first edge back in IDLE
    a = 8'd50; b = 8'd8; start = 1'b1;
    @(negedge clk);
    a = 8'd30; b = 8'd4;
    wait_done("held1");
    chk("held1 diff", diff, 8'd42);
    @(negedge clk);
    chk("held idle busy", busy, 1'b0);
    @(negedge clk);
    chk("held reaccept busy", busy, 1'b1);
    start = 1'b0;
    wait_done("held2");
    chk("held2 diff", diff, 8'd26);
    chk("held2 b_out", b_out, 1'b0);
    @(negedge clk);

    // async reset mid-RUN (count=4)
    @(negedge clk);
    a = 8'd200; b = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst busy", busy, 1'b0);
    chk("midrst done", done, 1'b0);
    chk("midrst diff", diff, 8'd0);
    chk("midrst b_out", b_out, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    run_vec(vecs[9], "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial, LSB-first subtractor computing diff = a - b - b_in, one bit per clock.
- Arithmetic inverse of the team's combinational full-adder chain.
- Trades area for latency: one full-subtractor cell plus shift registers and a borrow flip-flop.
- Sits behind a simple start/done handshake for use by sequencers that need low-area subtraction.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range >= 2).

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; sampled on the accepting edge.
- b  input  WIDTH  subtrahend; sampled on the accepting edge.
- b_in  input  1  borrow-in; sampled on the accepting edge.
- busy  output  1  high while an operation is in progress (RUN and DONE).
- done  output  1  one-cycle pulse; result valid.
- diff  output  WIDTH  result; held stable from done until the next accepted start.
- b_out  output  1  final borrow-out; held like diff.

Behaviour:
- Reset (async assert, any state): state=IDLE, busy=0, done=0, diff=0, b_out=0, count=0, operand shift regs=0, borrow FF=0. Takes effect immediately; any operation in flight is abandoned.
- FSM states IDLE, RUN, DONE; all outputs registered.
- IDLE:
  - start=1 at edge E0: load a_sh=a, b_sh=b, borrow=b_in, count=0; go to RUN; busy=1 from E0.
  - start=0: stay in IDLE.
- RUN, each edge:
  - d = a_sh[0] ^ b_sh[0] ^ borrow.
  - borrow <= (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & borrow).
  - diff_sh <= {d, diff_sh[WIDTH-1:1]}; a_sh and b_sh shift right by 1; count++.
- RUN exit: on the edge where count==WIDTH-1 (edge E_WIDTH), move to DONE and set done=1. diff and b_out are updated from the final shift on that same edge.
- DONE: lasts exactly one cycle; done=1, busy=1. The next edge returns to IDLE with done=0 and busy=0.
- Latency: done is high in the cycle after edge E_WIDTH. That is WIDTH cycles after the accepting edge; first accept-to-accept throughput is WIDTH+2 cycles.
- start while busy (RUN or DONE): ignored, not queued; operands are not re-sampled.
- start held continuously: a new operation is accepted on the first edge back in IDLE.
- diff and b_out are only updated during RUN.
- Between operations, diff and b_out keep the last result.
- diff wraps modulo 2^WIDTH; b_out=1 iff a < b + b_in (unsigned).
- Changes on a, b or b_in after acceptance have no effect.
- Count register width: $clog2(WIDTH).

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_OVERFLOW_EN.
- Defined:
  - Adds port ovf (output, 1 bit), the signed two's-complement overflow of a - b - b_in.
  - ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).
  - a[MSB] and b[MSB] are captured at accept.
  - ovf is registered alongside diff, reset to 0, and held with diff.
- Not defined: port and logic absent; all other behaviour identical.

Decomposition:
- Package serial_subtractor_pkg:
  - state typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - localparam function for count width.
- One sub-module: full_subtractor, purely combinational.
  - Ports: a, b, b_in, diff, b_out.
  - Instantiated once on the LSB path; the top holds all state.

Test Plan (WIDTH=8):
- a=8'd10, b=8'd3, b_in=0, start pulse → done exactly 8 cycles after accept edge, diff=8'd7, b_out=0, busy=1 for 9 cycles.
- a=8'd3, b=8'd10, b_in=0 → diff=8'hF9, b_out=1.
- a=8'h00, b=8'h00, b_in=1 → diff=8'hFF, b_out=1. Also a=8'hFF, b=8'h01, b_in=1 → diff=8'hFD, b_out=0.
- Accept a=8'd20, b=8'd5; pulse start with a=8'd1, b=8'd2 during RUN and during DONE → both ignored, diff=8'd15. A start held continuously is accepted on the first IDLE edge.
- Assert rst asynchronously mid-RUN (count=4) → busy, done, diff, b_out=0 immediately. After release, 8'd100-8'd1 → diff=8'd99.
- With SERIAL_SUBTRACTOR_OVERFLOW_EN:
  - 8'h80-8'h01 → diff=8'h7F, ovf=1.
  - 8'h7F-8'hFF → diff=8'h80, ovf=1.
  - 8'd5-8'd3 → ovf=0.
